// File: rtl/fir_load_sequencer.sv
// fir_load_sequencer: host-side feeder for the FIR sequencing controller.
// Accepts coefficients and buffered samples over valid/ready handshakes and
// issues them to the controller as lc / dr strobes, paced by its modwait flag.
// Optional build macro FIR_LOAD_TIMEOUT_EN adds a watchdog and a timeout_err
// pulse; without it the sequencer waits on modwait indefinitely.
module fir_load_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_COEFF  = 4
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        sample_valid,
  input  logic [15:0]                 sample_data,
  output logic                        sample_ready,
  input  logic                        coeff_valid,
  input  logic [15:0]                 coeff_data,
  output logic                        coeff_ready,
  input  logic                        modwait,
  output logic                        dr,
  output logic                        lc,
  output logic [15:0]                 data_out,
  output logic                        coeff_loaded,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef FIR_LOAD_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDX_W  = $clog2(NUM_COEFF + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    C_PULSE = 3'd1,
    C_BUSY  = 3'd2,
    S_ISSUE = 3'd3,
    S_BUSY  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                loaded_nxt;
  logic [IDX_W-1:0]    coeff_idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic                seen_hi;
  logic                seen_nxt;
  logic                issue_first;
  logic                first_nxt;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                push_c;
  logic                pop_c;
  logic [DATA_W-1:0]   fifo_head_c;

`ifdef FIR_LOAD_TIMEOUT_EN
  logic [2:0]          wd_cnt;
  logic [2:0]          wd_nxt;
  logic                tmo_nxt;
`endif

  // Handshake readiness: FIFO not full; coefficients only in an idle, quiet controller
  assign sample_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign coeff_ready  = (state == IDLE) && !modwait;
  assign push_c       = sample_valid && sample_ready;
  assign fifo_head_c  = mem[rd_ptr];

  // Sample storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= sample_data;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // Next-state and next-output logic for the issue sequencer
  always_comb begin
    state_nxt  = state;
    data_nxt   = data_out;
    loaded_nxt = coeff_loaded;
    idx_nxt    = coeff_idx;
    seen_nxt   = seen_hi;
    first_nxt  = 1'b0;
    pop_c      = 1'b0;
`ifdef FIR_LOAD_TIMEOUT_EN
    wd_nxt     = 3'd0;
    tmo_nxt    = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (!modwait) begin
          if (coeff_valid) begin
            // a coefficient arriving after a complete set restarts the load
            data_nxt  = coeff_data;
            state_nxt = C_PULSE;
            if (coeff_loaded) begin
              loaded_nxt = 1'b0;
              idx_nxt    = '0;
            end
          end else if ((fifo_count != '0) && coeff_loaded) begin
            data_nxt  = fifo_head_c;
            pop_c     = 1'b1;
            first_nxt = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end

      C_PULSE: begin
        seen_nxt  = 1'b0;
        state_nxt = C_BUSY;
      end

      C_BUSY: begin
        if (seen_hi && !modwait) begin
          seen_nxt  = 1'b0;
          state_nxt = IDLE;
          if (coeff_idx == IDX_W'(NUM_COEFF - 1)) begin
            loaded_nxt = 1'b1;
            idx_nxt    = '0;
          end else begin
            idx_nxt = coeff_idx + IDX_W'(1);
          end
        end else if (modwait) begin
          seen_nxt = 1'b1;
        end
      end

      S_ISSUE: begin
        // the first cycle is skipped so dr is seen twice by the controller
        if (modwait && !issue_first) begin
          state_nxt = S_BUSY;
        end
      end

      S_BUSY: begin
        if (!modwait) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef FIR_LOAD_TIMEOUT_EN
    // watchdog: a controller that never raises modwait abandons the transfer
    if (((state == S_ISSUE) || ((state == C_BUSY) && !seen_hi)) && !modwait) begin
      if (wd_cnt == 3'd6) begin
        tmo_nxt   = 1'b1;
        seen_nxt  = 1'b0;
        state_nxt = IDLE;
      end else begin
        wd_nxt = wd_cnt + 3'd1;
      end
    end
`endif
  end

  // State and registered outputs; strobes decode the upcoming state
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      lc           <= 1'b0;
      dr           <= 1'b0;
      data_out     <= '0;
      coeff_loaded <= 1'b0;
      coeff_idx    <= '0;
      seen_hi      <= 1'b0;
      issue_first  <= 1'b0;
    end else begin
      state        <= state_nxt;
      lc           <= (state_nxt == C_PULSE);
      dr           <= (state_nxt == S_ISSUE);
      data_out     <= data_nxt;
      coeff_loaded <= loaded_nxt;
      coeff_idx    <= idx_nxt;
      seen_hi      <= seen_nxt;
      issue_first  <= first_nxt;
    end
  end

`ifdef FIR_LOAD_TIMEOUT_EN
  // Watchdog counter and single-cycle timeout pulse
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wd_cnt      <= 3'd0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt      <= wd_nxt;
      timeout_err <= tmo_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fir_load_sequencer.sv
// Directed bench for fir_load_sequencer with a simple registered controller model.
module tb_fir_load_sequencer;

  logic        clk;
  logic        n_reset;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic        coeff_valid;
  logic [15:0] coeff_data;
  logic        coeff_ready;
  logic        modwait;
  logic        dr;
  logic        lc;
  logic [15:0] data_out;
  logic        coeff_loaded;
  logic [2:0]  fifo_count;
`ifdef FIR_LOAD_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fir_load_sequencer #(.FIFO_DEPTH(4), .NUM_COEFF(4)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .coeff_valid  (coeff_valid),
    .coeff_data   (coeff_data),
    .coeff_ready  (coeff_ready),
    .modwait      (modwait),
    .dr           (dr),
    .lc           (lc),
    .data_out     (data_out),
    .coeff_loaded (coeff_loaded),
    .fifo_count   (fifo_count)
`ifdef FIR_LOAD_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: a strobe seen at a clock edge holds modwait high for 3 cycles
  logic mw_force = 1'b0;
  logic ctrl_off = 1'b0;
  int   busy_cnt = 0;
  always @(posedge clk) begin : ctrl_model
    logic strobe;
    strobe = (lc || dr) && n_reset;
    #1;
    if (!n_reset) busy_cnt = 0;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    else if (strobe && !ctrl_off) busy_cnt = 3;
    modwait = mw_force || (busy_cnt > 0);
  end

  // Record every issued sample word and any lc/dr overlap
  logic [15:0] issued[$];
  int          overlap = 0;
  logic        dr_prev = 1'b0;
  always @(negedge clk) begin
    if (dr && !dr_prev) issued.push_back(data_out);
    dr_prev = dr;
    if (lc && dr) overlap++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_coeff(input logic [15:0] val, input logic exp_loaded);
    int n;
    n = 0;
    while (!coeff_ready && n < 50) begin step(); n++; end
    check("coeff_ready", 32'(coeff_ready), 32'd1);
    coeff_valid = 1'b1;
    coeff_data  = val;
    step();
    coeff_valid = 1'b0;
    check("lc_pulse", 32'(lc), 32'd1);
    check("lc_word", 32'(data_out), 32'(val));
    check("lc_no_dr", 32'(dr), 32'd0);
    step();
    check("lc_single", 32'(lc), 32'd0);
    n = 0;
    while (!coeff_ready && n < 50) begin step(); n++; end
    check("reentry_cycles", 32'(n), 32'd4);
    check("loaded_flag", 32'(coeff_loaded), 32'(exp_loaded));
  endtask

  task automatic push_sample(input logic [15:0] val);
    sample_valid = 1'b1;
    sample_data  = val;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin : stim
    int n;
    logic [15:0] exp_a [5];
    exp_a = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    n_reset      = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    coeff_valid  = 1'b0;
    coeff_data   = '0;
    modwait      = 1'b0;

    // reset values
    step(); step();
    check("rst_dr", 32'(dr), 32'd0);
    check("rst_lc", 32'(lc), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_loaded", 32'(coeff_loaded), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_sready", 32'(sample_ready), 32'd1);
    check("rst_cready", 32'(coeff_ready), 32'd1);
    n_reset = 1'b1;
    step();

    // sample before coefficients stays buffered
    push_sample(16'h1234);
    check("early_count", 32'(fifo_count), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("early_no_dr", 32'(dr), 32'd0);
    end

    // four coefficients, then the buffered sample issues
    load_coeff(16'h0001, 1'b0);
    load_coeff(16'h0002, 1'b0);
    load_coeff(16'h0003, 1'b0);
    load_coeff(16'h0004, 1'b1);
    step();
    check("issue_dr", 32'(dr), 32'd1);
    check("issue_word", 32'(data_out), 32'h1234);
    check("issue_count", 32'(fifo_count), 32'd0);
    n = 1;
    step();
    while (dr && n < 20) begin n++; step(); end
    check("dr_hold", 32'(n), 32'd2);

    // fill FIFO while controller busy, then drain in order across the wrap
    n = 0;
    while (!coeff_ready && n < 50) begin step(); n++; end
    issued.delete();
    mw_force = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      sample_valid = 1'b1;
      sample_data  = exp_a[k];
      step();
      check("fill_count", 32'(fifo_count), 32'(k + 1));
    end
    check("full_ready", 32'(sample_ready), 32'd0);
    sample_data = exp_a[4];
    step();
    check("full_hold", 32'(fifo_count), 32'd4);
    mw_force = 1'b0;
    n = 0;
    while (!sample_ready && n < 50) begin step(); n++; end
    step();
    sample_valid = 1'b0;
    n = 0;
    while ((issued.size() < 5 || !coeff_ready || fifo_count != 0) && n < 300) begin step(); n++; end
    check("drain_num", 32'(issued.size()), 32'd5);
    for (int k = 0; k < 5; k++) check($sformatf("order%0d", k), 32'(issued[k]), 32'(exp_a[k]));

    // coefficient and pending sample in the same idle cycle: lc wins
    issued.delete();
    mw_force = 1'b1;
    step();
    push_sample(16'hB001);
    check("pend_count", 32'(fifo_count), 32'd1);
    coeff_valid = 1'b1;
    coeff_data  = 16'h00C1;
    mw_force    = 1'b0;
    n = 0;
    while (!lc && n < 20) begin step(); n++; end
    coeff_valid = 1'b0;
    check("prio_lc", 32'(lc), 32'd1);
    check("prio_no_dr", 32'(dr), 32'd0);
    check("prio_word", 32'(data_out), 32'h00C1);
    check("reload_clr", 32'(coeff_loaded), 32'd0);
    load_coeff(16'h00C2, 1'b0);
    load_coeff(16'h00C3, 1'b0);
    check("held_count", 32'(fifo_count), 32'd1);
    check("held_none", 32'(issued.size()), 32'd0);
    load_coeff(16'h00C4, 1'b1);
    n = 0;
    while (!(coeff_ready && fifo_count == 0 && issued.size() >= 1) && n < 100) begin step(); n++; end
    check("after_lc_num", 32'(issued.size()), 32'd1);
    check("after_lc_word", 32'(issued[0]), 32'hB001);

    // reset during S_BUSY with three samples queued
    mw_force = 1'b1;
    step();
    push_sample(16'hD001);
    push_sample(16'hD002);
    push_sample(16'hD003);
    push_sample(16'hD004);
    check("q4_count", 32'(fifo_count), 32'd4);
    mw_force = 1'b0;
    n = 0;
    while (!dr && n < 50) begin step(); n++; end
    n = 0;
    while (dr && n < 50) begin step(); n++; end
    check("busy_q3", 32'(fifo_count), 32'd3);
    check("busy_word", 32'(data_out), 32'hD001);
    n_reset = 1'b0;
    #1;
    check("mid_rst_dr", 32'(dr), 32'd0);
    check("mid_rst_lc", 32'(lc), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_loaded", 32'(coeff_loaded), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_sready", 32'(sample_ready), 32'd1);
    step();
    check("mid_rst_cready", 32'(coeff_ready), 32'd1);
    n_reset = 1'b1;
    step();
    push_sample(16'hE001);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_no_dr", 32'(dr), 32'd0);
    end

`ifdef FIR_LOAD_TIMEOUT_EN
    // watchdog fires when the controller never answers dr
    load_coeff(16'h0011, 1'b0);
    load_coeff(16'h0012, 1'b0);
    load_coeff(16'h0013, 1'b0);
    load_coeff(16'h0014, 1'b1);
    n = 0;
    while (!(coeff_ready && fifo_count == 0 && !dr) && n < 100) begin step(); n++; end
    ctrl_off = 1'b1;
    push_sample(16'hF001);
    n = 0;
    while (!dr && n < 20) begin step(); n++; end
    n = 0;
    while (!timeout_err && n < 20) begin step(); n++; end
    check("tmo_cycles", 32'(n), 32'd7);
    check("tmo_dr_low", 32'(dr), 32'd0);
    check("tmo_idle", 32'(coeff_ready), 32'd1);
    step();
    check("tmo_pulse", 32'(timeout_err), 32'd0);
    ctrl_off = 1'b0;
`endif

    check("lc_dr_overlap", 32'(overlap), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
